// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to registered valid/ready stream adapter
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err,
  input  logic                  clear_err
);

  // Two-entry output buffer: buf0 is the head presented on m_data, buf1 the tail.
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic                  underflow_err_q, underflow_err_d;

  logic                  pop;
  logic                  push;
  logic [2:0]            committed;

  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = buf0_q;
  assign rd_count      = rd_count_q;
  assign underflow_err = underflow_err_q;

  assign pop  = m_valid && m_ready;
  assign push = inflight_q && !fifo_underflow;

  // Slots already spoken for after this cycle's pop; a new read needs one free slot.
  // pop implies occ >= 1, so the subtraction never goes negative.
  assign committed  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  // Read request is combinational so a same-cycle pop frees a slot immediately;
  // gated by rst_n so no read is requested while the buffer is held in reset.
  assign fifo_rd_en = rst_n && enable && !fifo_empty && (committed < 3'd2);

  // Next-state for the buffer, occupancy, counter and sticky error.
  always_comb begin
    occ_d           = occ_q;
    inflight_d      = fifo_rd_en;
    buf0_d          = buf0_q;
    buf1_d          = buf1_q;
    rd_count_d      = rd_count_q;
    underflow_err_d = underflow_err_q;

    unique case ({push, pop})
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_data_out;
        end else begin
          buf1_d = fifo_data_out;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        // Head leaves; the older tail (if any) moves up ahead of the returning word.
        if (occ_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_out;
        end else begin
          buf0_d = fifo_data_out;
        end
      end
      default: begin
      end
    endcase

    if (pop) begin
      rd_count_d = rd_count_q + CNT_WIDTH'(1);
    end

    // A fresh underflow takes priority over a simultaneous clear.
    if (inflight_q && fifo_underflow) begin
      underflow_err_d = 1'b1;
    end else if (clear_err) begin
      underflow_err_d = 1'b0;
    end
  end

  // State registers; reset drops buffered and in-flight words at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q           <= 2'd0;
      inflight_q      <= 1'b0;
      buf0_q          <= '0;
      buf1_q          <= '0;
      rd_count_q      <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      occ_q           <= occ_d;
      inflight_q      <= inflight_d;
      buf0_q          <= buf0_d;
      buf1_q          <= buf1_d;
      rd_count_q      <= rd_count_d;
      underflow_err_q <= underflow_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

  localparam int FW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [FW-1:0] fifo_data_out = '0;
  logic          fifo_underflow = 1'b0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [FW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] rd_count;
  logic          underflow_err;
  logic          clear_err = 1'b0;

  fifo_rd_stream #(.FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .rd_count      (rd_count),
    .underflow_err (underflow_err),
    .clear_err     (clear_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Environment FIFO contents and reference model state.
  logic [FW-1:0] fq[$];      // words sitting in the attached FIFO
  logic [FW-1:0] eq_d[$];    // words read and owed to the consumer, in order
  int            eq_a[$];    // cycle from which each owed word may be visible
  int            cyc = 0;
  int            outstanding = 0;  // reads issued, not yet accepted or dropped
  int            uf_due = -1;
  bit            clr_prev = 0;
  bit            m_err = 0;
  logic [CW-1:0] m_cnt = '0;
  bit            force_uf = 0;
  bit            last_rd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, let the edge happen, update models.
  task automatic step(input bit rdy, input bit en, input bit clr);
    bit            exp_valid, pop, exp_rd, rd;
    logic [FW-1:0] w;
    if (clr_prev) m_err = 0;
    if (uf_due == cyc) begin
      m_err = 1;
      outstanding--;
    end
    m_ready    = rdy;
    enable     = en;
    clear_err  = clr;
    fifo_empty = (fq.size() == 0);
    #1;
    exp_valid = (eq_d.size() > 0) && (eq_a[0] <= cyc);
    pop       = exp_valid && rdy;
    exp_rd    = en && !fifo_empty && ((outstanding - int'(pop)) < 2);
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(m_data), 32'(eq_d[0]));
    check("rd_count", 32'(rd_count), 32'(m_cnt));
    check("underflow_err", 32'(underflow_err), 32'(m_err));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    rd      = fifo_rd_en;
    last_rd = rd;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(eq_d.pop_front());
      void'(eq_a.pop_front());
      m_cnt++;
      outstanding--;
    end
    if (rd) begin
      outstanding++;
      if (fq.size() > 0) begin
        w = fq.pop_front();
        fifo_data_out = w;
        if (force_uf) begin
          fifo_underflow = 1'b1;
          force_uf = 0;
          uf_due = cyc + 2;
        end else begin
          fifo_underflow = 1'b0;
          eq_d.push_back(w);
          eq_a.push_back(cyc + 2);
        end
      end else begin
        fifo_underflow = 1'b1;
        uf_due = cyc + 2;
      end
    end else begin
      fifo_underflow = 1'b0;
    end
    clr_prev = clr;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_underflow_err", 32'(underflow_err), 32'd0);
    check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    eq_d.delete();
    eq_a.delete();
    outstanding = 0;
    m_cnt = '0;
    m_err = 0;
    uf_due = -1;
    clr_prev = 0;
    force_uf = 0;
    fifo_underflow = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Straight stream of 8 words with the consumer always ready.
    for (int i = 1; i <= 8; i++) fq.push_back(FW'(i));
    repeat (14) step(1, 1, 0);

    // Back-pressure: 10 stalled cycles, then release.
    for (int i = 0; i < 5; i++) fq.push_back(FW'(16'h0100 + i));
    repeat (10) step(0, 1, 0);
    repeat (10) step(1, 1, 0);

    // Alternating ready over 6 words.
    for (int i = 0; i < 6; i++) fq.push_back(FW'(16'h0200 + i));
    for (int i = 0; i < 16; i++) step(i[0], 1, 0);

    // Forced underflow on a return cycle, then a clear pulse.
    for (int i = 0; i < 3; i++) fq.push_back(FW'(16'h0300 + i));
    step(1, 1, 0);
    force_uf = 1;
    repeat (6) step(1, 1, 0);
    step(1, 1, 1);
    repeat (3) step(1, 1, 0);

    // Disable right after a read is issued.
    for (int i = 0; i < 4; i++) fq.push_back(FW'(16'h0400 + i));
    last_rd = 0;
    for (int i = 0; i < 10 && !last_rd; i++) step(1, 1, 0);
    check("enable_read_seen", 32'(last_rd), 32'd1);
    repeat (8) step(1, 0, 0);
    repeat (8) step(1, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) fq.push_back(FW'($urandom));
      if (!force_uf && $urandom_range(0, 24) == 0) force_uf = 1;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9, $urandom_range(0, 19) == 0);
    end

    // Reset mid-stream with words buffered.
    fq.delete();
    for (int i = 0; i < 6; i++) fq.push_back(FW'(16'h0500 + i));
    repeat (4) step(0, 1, 0);
    do_reset();
    repeat (10) step(1, 1, 0);

    // Counter wrap: 17 accepted words from reset.
    fq.delete();
    do_reset();
    for (int i = 0; i < 17; i++) fq.push_back(FW'(16'h0600 + i));
    repeat (25) step(1, 1, 0);
    check("rd_count_wrap", 32'(rd_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
